// File: rtl/msix_irq_req_rx_if.sv
// AXI4-lite bundle between an interrupt-doorbell master and msix_irq_req_rx.
// master: fabric/initiator side; slave: the doorbell responder.
interface msix_irq_req_rx_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 64
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/msix_irq_req_rx.sv
// msix_irq_req_rx: AXI4-lite doorbell responder that turns interrupt-request
// writes into an ordered stream of MSI-X vector requests. One pending bit per
// vector; repeat requests for a pending vector are merged (coalesced).
// Optional macro MSIX_RX_COALESCE_CNT_EN compiles in a saturating 32-bit
// coalesce counter readable in status bits [63:32].
module msix_irq_req_rx #(
  parameter int          ADDR_WIDTH      = 21,
  parameter int          DATA_WIDTH      = 64,
  parameter logic [11:0] DOORBELL_OFFSET = 12'h010,
  parameter logic [11:0] STATUS_OFFSET   = 12'h018,
  parameter int          NUM_VECTORS     = 8,
  localparam int         VW              = $clog2(NUM_VECTORS)
) (
  input  logic                clk,
  input  logic                rst_n,
  msix_irq_req_rx_if.slave    axi,
  output logic                irq_valid,
  input  logic                irq_ready,
  output logic [VW-1:0]       irq_vector
);

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;

  // Write-side state
  wstate_t          state_q, state_d;
  logic             aw_held_q, aw_held_d;
  logic             w_held_q, w_held_d;
  logic [11:0]      awaddr_q, awaddr_d;
  logic [7:0]       wbyte_q, wbyte_d;
  logic             wstrb0_q, wstrb0_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;

  // Read-side state
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Pending bits and vector FIFO (occupancy always equals popcount(pending))
  logic [NUM_VECTORS-1:0] pending_q, pending_d;
  logic [VW-1:0]          mem_q [NUM_VECTORS];
  logic [VW-1:0]          mem_d [NUM_VECTORS];
  logic [VW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [VW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [VW:0]            count_q, count_d;

  // Combinational helpers
  logic                   aw_fire, w_fire, ar_fire, pop, commit;
  logic [11:0]            c_addr;
  logic [7:0]             c_byte;
  logic                   c_strb;
  logic [VW-1:0]          v_idx, head;
  logic                   push, coalesce, slverr;
  logic [NUM_VECTORS-1:0] pop_mask, push_mask, pending_eff;
  logic [31:0]            pend32;
  logic [31:0]            coal_val;

`ifdef MSIX_RX_COALESCE_CNT_EN
  logic [31:0] coal_cnt_q, coal_cnt_d;

  // Saturating count of merged doorbells
  always_comb begin
    coal_cnt_d = coal_cnt_q;
    if (coalesce && (coal_cnt_q != 32'hFFFF_FFFF)) coal_cnt_d = coal_cnt_q + 32'd1;
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) coal_cnt_q <= 32'd0;
    else        coal_cnt_q <= coal_cnt_d;
  end

  assign coal_val = coal_cnt_q;
  logic unused_cnt;
  assign unused_cnt = 1'b0;
`else
  assign coal_val = 32'd0;
  logic unused_cnt;
  assign unused_cnt = coalesce;
`endif

  // Next-state logic: AW/W capture, doorbell decode, pending/FIFO update, reads
  always_comb begin
    aw_fire = axi.awvalid & awready_q;
    w_fire  = axi.wvalid & wready_q;
    ar_fire = axi.arvalid & arready_q;

    head     = mem_q[rd_ptr_q];
    pop      = (count_q != '0) & irq_ready;
    pop_mask = '0;
    if (pop) pop_mask[head] = 1'b1;
    // Pop of this cycle takes effect before the doorbell lookup, so a request
    // for the vector leaving the head is queued again as a fresh entry.
    pending_eff = pending_q & ~pop_mask;

    c_addr = aw_fire ? axi.awaddr[11:0] : awaddr_q;
    c_byte = w_fire  ? axi.wdata[7:0]   : wbyte_q;
    c_strb = w_fire  ? axi.wstrb[0]     : wstrb0_q;
    v_idx  = c_byte[VW-1:0];
    commit = (state_q == W_IDLE) & (aw_held_q | aw_fire) & (w_held_q | w_fire);

    push     = 1'b0;
    coalesce = 1'b0;
    slverr   = 1'b0;
    if (commit && (c_addr == DOORBELL_OFFSET) && c_strb) begin
      if ({24'd0, c_byte} >= 32'(NUM_VECTORS)) slverr = 1'b1;
      else if (pending_eff[v_idx])             coalesce = 1'b1;
      else                                     push = 1'b1;
    end
    push_mask = '0;
    if (push) push_mask[v_idx] = 1'b1;
    pending_d = pending_eff | push_mask;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = v_idx;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (VW+1)'(push) - (VW+1)'(pop);

    // Write channel FSM
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wbyte_d   = wbyte_q;
    wstrb0_d  = wstrb0_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = axi.awaddr[11:0];
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wbyte_d  = axi.wdata[7:0];
          wstrb0_d = axi.wstrb[0];
        end
        awready_d = ~(aw_held_q | aw_fire);
        wready_d  = ~(w_held_q | w_fire);
        if (commit) begin
          state_d   = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = slverr ? 2'b10 : 2'b00;
        end
      end
      default: begin
        if (bvalid_q && axi.bready) begin
          state_d   = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
    endcase

    // Read channel: one outstanding read, data snapshot taken at accept
    pend32 = '0;
    pend32[NUM_VECTORS-1:0] = pending_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && axi.rready) rvalid_d = 1'b0;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = (axi.araddr[11:0] == STATUS_OFFSET) ? DATA_WIDTH'({coal_val, pend32}) : '0;
    end
    arready_d = ~rvalid_d;
  end

  // State registers; reset clears everything, including any held AW/W
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wbyte_q   <= '0;
      wstrb0_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < NUM_VECTORS; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wbyte_q   <= wbyte_d;
      wstrb0_q  <= wstrb0_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      for (int i = 0; i < NUM_VECTORS; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = 2'b00;
  assign irq_valid   = (count_q != '0);
  assign irq_vector  = head;

  // Protection bits, upper address bits and unused data lanes carry no meaning
  logic unused_ok;
  assign unused_ok = &{1'b0, axi.awprot, axi.arprot, axi.awaddr[ADDR_WIDTH-1:12],
                       axi.araddr[ADDR_WIDTH-1:12], axi.wdata[DATA_WIDTH-1:8],
                       axi.wstrb[DATA_WIDTH/8-1:1], unused_cnt};

endmodule

// File: tb/tb_msix_irq_req_rx.sv
// Directed testbench for msix_irq_req_rx (default 8 vectors, 64-bit data).
module tb_msix_irq_req_rx;

`ifdef MSIX_RX_COALESCE_CNT_EN
  localparam logic [31:0] COAL_EN = 32'd1;
`else
  localparam logic [31:0] COAL_EN = 32'd0;
`endif
  localparam logic [11:0] DB  = 12'h010;
  localparam logic [11:0] ST  = 12'h018;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       irq_valid;
  logic       irq_ready = 1'b0;
  logic [2:0] irq_vector;

  int checks = 0;
  int errors = 0;

  msix_irq_req_rx_if #(.ADDR_WIDTH(21), .DATA_WIDTH(64)) axi ();

  msix_irq_req_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axi        (axi.slave),
    .irq_valid  (irq_valid),
    .irq_ready  (irq_ready),
    .irq_vector (irq_vector)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [7:0] data,
                           input logic [7:0] strb, output logic [1:0] resp);
    int  n;
    logic aw_done, w_done;
    axi.awaddr  = {9'd0, addr};
    axi.wdata   = {56'd0, data};
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      if (axi.awvalid && axi.awready) aw_done = 1'b1;
      if (axi.wvalid && axi.wready)   w_done  = 1'b1;
      tick();
      if (aw_done) axi.awvalid = 1'b0;
      if (w_done)  axi.wvalid  = 1'b0;
      n++;
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    if (n >= 20) check("wr_accept_timeout", 64'd0, 64'd1);
    check("bvalid_lat", {63'd0, axi.bvalid}, 64'd1);
    resp = axi.bresp;
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    $display("wr addr=%03h data=%02h strb=%02h resp=%0d", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [63:0] data);
    int n;
    axi.araddr  = {9'd0, addr};
    axi.arvalid = 1'b1;
    n = 0;
    while (!axi.arready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ar_accept_timeout", 64'd0, 64'd1);
    tick();
    axi.arvalid = 1'b0;
    check("rvalid_lat", {63'd0, axi.rvalid}, 64'd1);
    check("rresp", {62'd0, axi.rresp}, 64'd0);
    data = axi.rdata;
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    $display("rd addr=%03h data=%016h", addr, data);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [63:0] rd;

    axi.awvalid = 1'b0; axi.awaddr = '0; axi.awprot = 3'd0;
    axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb  = '0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = '0; axi.arprot = 3'd0;
    axi.rready  = 1'b0;

    // Reset: outputs all zero, readys rise one clock after release
    repeat (4) tick();
    check("rst_awready", {63'd0, axi.awready}, 64'd0);
    check("rst_wready",  {63'd0, axi.wready},  64'd0);
    check("rst_arready", {63'd0, axi.arready}, 64'd0);
    check("rst_bvalid",  {63'd0, axi.bvalid},  64'd0);
    check("rst_rvalid",  {63'd0, axi.rvalid},  64'd0);
    check("rst_rdata",   axi.rdata,            64'd0);
    check("rst_irq_valid",  {63'd0, irq_valid}, 64'd0);
    check("rst_irq_vector", {61'd0, irq_vector}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_awready", {63'd0, axi.awready}, 64'd1);
    check("post_wready",  {63'd0, axi.wready},  64'd1);
    check("post_arready", {63'd0, axi.arready}, 64'd1);
    check("post_irq_valid", {63'd0, irq_valid}, 64'd0);

    // Single doorbell for vector 6
    axi_write(DB, 8'd6, 8'hFF, resp);
    check("db6_bresp", {62'd0, resp}, 64'd0);
    check("db6_irq_valid", {63'd0, irq_valid}, 64'd1);
    check("db6_irq_vector", {61'd0, irq_vector}, 64'd6);
    axi_read(ST, rd);
    check("db6_pending", {32'd0, rd[31:0]}, 64'h40);
    check("db6_cnt", {32'd0, rd[63:32]}, 64'd0);
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    check("db6_drained", {63'd0, irq_valid}, 64'd0);
    axi_read(ST, rd);
    check("db6_pending_clr", {32'd0, rd[31:0]}, 64'h0);

    // Ordering and coalesce: 3, 5, 3
    axi_write(DB, 8'd3, 8'h01, resp);
    check("ord3_bresp", {62'd0, resp}, 64'd0);
    axi_write(DB, 8'd5, 8'h01, resp);
    check("ord5_bresp", {62'd0, resp}, 64'd0);
    axi_write(DB, 8'd3, 8'h01, resp);
    check("coal3_bresp", {62'd0, resp}, 64'd0);
    axi_read(ST, rd);
    check("ord_pending", {32'd0, rd[31:0]}, 64'h28);
    check("ord_cnt", {32'd0, rd[63:32]}, {32'd0, COAL_EN});
    irq_ready = 1'b1;
    check("drain_v0", {62'd0, irq_valid, 1'b0} | {61'd0, irq_vector}, 64'h3 | 64'h2);
    check("drain_first", {61'd0, irq_vector}, 64'd3);
    tick();
    check("drain_second_valid", {63'd0, irq_valid}, 64'd1);
    check("drain_second", {61'd0, irq_vector}, 64'd5);
    tick();
    irq_ready = 1'b0;
    check("drain_empty", {63'd0, irq_valid}, 64'd0);

    // Out-of-range vector, strobe-less doorbell, other address
    axi_write(DB, 8'd8, 8'h01, resp);
    check("oob_bresp", {62'd0, resp}, 64'd2);
    axi_write(DB, 8'd4, 8'hFE, resp);
    check("nostrb_bresp", {62'd0, resp}, 64'd0);
    axi_write(12'h020, 8'd1, 8'h01, resp);
    check("otheraddr_bresp", {62'd0, resp}, 64'd0);
    check("ignored_no_irq", {63'd0, irq_valid}, 64'd0);
    axi_read(ST, rd);
    check("ignored_pending", {32'd0, rd[31:0]}, 64'h0);
    axi_read(12'h020, rd);
    check("other_rdata", rd, 64'h0);

    // W presented three cycles ahead of AW
    axi.wdata  = 64'd1;
    axi.wstrb  = 8'h01;
    axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    check("wfirst_wready_low", {63'd0, axi.wready}, 64'd0);
    check("wfirst_awready", {63'd0, axi.awready}, 64'd1);
    tick();
    tick();
    check("wfirst_no_bvalid", {63'd0, axi.bvalid}, 64'd0);
    axi.awaddr  = {9'd0, DB};
    axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    check("wfirst_bvalid", {63'd0, axi.bvalid}, 64'd1);
    check("wfirst_bresp", {62'd0, axi.bresp}, 64'd0);
    check("wfirst_irq_vector", {61'd0, irq_vector}, 64'd1);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    check("wfirst_bvalid_clr", {63'd0, axi.bvalid}, 64'd0);
    $display("wr W-before-AW addr=%03h data=01", DB);
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    check("wfirst_drained", {63'd0, irq_valid}, 64'd0);

    // Same-cycle pop and push of vector 2
    axi_write(DB, 8'd2, 8'h01, resp);
    check("pp_first_vec", {61'd0, irq_vector}, 64'd2);
    axi.awaddr  = {9'd0, DB};
    axi.wdata   = 64'd2;
    axi.wstrb   = 8'h01;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    irq_ready   = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    irq_ready   = 1'b0;
    check("pp_bvalid", {63'd0, axi.bvalid}, 64'd1);
    check("pp_requeued_valid", {63'd0, irq_valid}, 64'd1);
    check("pp_requeued_vec", {61'd0, irq_vector}, 64'd2);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    $display("wr pop/push addr=%03h data=02", DB);
    axi_read(ST, rd);
    check("pp_pending", {32'd0, rd[31:0]}, 64'h4);
    check("pp_cnt", {32'd0, rd[63:32]}, {32'd0, COAL_EN});
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    check("pp_drained", {63'd0, irq_valid}, 64'd0);

    // Fill all vectors, coalesce one more, then reset mid-response
    for (int v = 0; v < 8; v++) begin
      axi_write(DB, 8'(v), 8'h01, resp);
      check("fill_bresp", {62'd0, resp}, 64'd0);
    end
    axi_write(DB, 8'd7, 8'h01, resp);
    axi_read(ST, rd);
    check("fill_pending", {32'd0, rd[31:0]}, 64'hFF);
    check("fill_cnt", {32'd0, rd[63:32]}, {32'd0, COAL_EN * 32'd2});
    check("fill_head", {61'd0, irq_vector}, 64'd0);
    axi.awaddr  = {9'd0, 12'h020};
    axi.wdata   = 64'd0;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    check("midrst_bvalid_before", {63'd0, axi.bvalid}, 64'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_bvalid", {63'd0, axi.bvalid}, 64'd0);
    check("midrst_irq_valid", {63'd0, irq_valid}, 64'd0);
    check("midrst_awready", {63'd0, axi.awready}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_bvalid_after", {63'd0, axi.bvalid}, 64'd0);
    axi_read(ST, rd);
    check("midrst_status", rd, 64'h0);
    check("midrst_irq_after", {63'd0, irq_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/msix_irq_req_rx.md
# msix_irq_req_rx

AXI4-lite responder that terminates interrupt-request doorbell writes from FIM sideband masters (FME, ports) and turns them into a serialized stream of MSI-X vector requests for the PCIe interrupt sender. Each doorbell write carries a vector number; the block tracks one pending bit per vector, merges repeat requests for a vector that is already pending, and holds queued vectors in arrival order until the downstream sender accepts them. It sits in the ST2MM/PCIe-bridge CSR space, behind the AXI4-lite fabric that carries FME interrupt writes.

## Interface
- ADDR_WIDTH, 21, AXI4-lite address width
- DATA_WIDTH, 64, AXI4-lite data width
- DOORBELL_OFFSET, 12'h010, write-only doorbell register offset (compared on addr[11:0])
- STATUS_OFFSET, 12'h018, read-only status register offset (addr[11:0])
- NUM_VECTORS, 8, supported vectors (power of 2, 2..32); VW = $clog2(NUM_VECTORS)

- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- awvalid/awready  in/out  1/1  write address handshake
- awaddr  in  ADDR_WIDTH  write address
- awprot  in  3  ignored
- wvalid/wready  in/out  1/1  write data handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- bvalid/bready  out/in  1/1  write response handshake
- bresp  out  2  OKAY 2'b00 / SLVERR 2'b10
- arvalid/arready  in/out  1/1  read address handshake
- araddr  in  ADDR_WIDTH  read address
- arprot  in  3  ignored
- rvalid/rready  out/in  1/1  read data handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  always OKAY
- irq_valid  out  1  vector request available
- irq_ready  in  1  downstream sender accepts
- irq_vector  out  VW  vector to signal

## Operation
- Write channel FSM: W_IDLE -> W_RESP. In W_IDLE, AW and W are captured independently (either order or same cycle); awready low once AW held, wready low once W held. Both held -> commit, go W_RESP, bvalid=1. W_RESP -> W_IDLE on bvalid&bready; awready/wready stay low in W_RESP.
- Commit decode: addr[11:0]==DOORBELL_OFFSET and wstrb[0]=1 is a doorbell; v = wdata[7:0].
  - v >= NUM_VECTORS: bresp=SLVERR, no state change.
  - pending_eff[v]=1: coalesce, bresp=OKAY, no push; coalesce counter +1.
  - else: set pending[v], push v into FIFO, bresp=OKAY.
  - Doorbell with wstrb[0]=0, or any other address: ignored, bresp=OKAY.
- pending_eff = pending & ~pop_mask (pop of the same cycle applied first). pending_next = pending_eff | push_mask. A doorbell for vector v arriving in the same cycle v is popped is queued as a new entry.
- FIFO: depth NUM_VECTORS, never overflows (occupancy == popcount(pending)). irq_valid = FIFO non-empty; irq_vector = head. irq_valid&irq_ready pops head and clears its pending bit. irq_vector stable while irq_valid & ~irq_ready.
- Read channel: arready=1 when rvalid=0. Accepted read -> rvalid next cycle, held until rready. STATUS_OFFSET: rdata[31:0] = pending zero-extended, rdata[63:32] = coalesce counter. Any other address: rdata=0. rresp always OKAY.

## Timing
- Reset values: awready=0, wready=0, arready=0, bvalid=0, bresp=0, rvalid=0, rdata=0, rresp=0, irq_valid=0, irq_vector=0, pending=0, counter=0, FIFO empty. Ready signals go to 1 on the first clock after rst_n deasserts.
- Write: AW and W in same cycle N -> bvalid high at N+1. Pending/FIFO update on the same edge. irq_valid high at N+1 if FIFO was empty.
- Back-to-back writes: next AW/W accepted earliest the cycle after bvalid&bready. Max rate is 1 doorbell per 2 cycles with bready tied high.
- Read: ar accepted cycle N -> rvalid at N+1.
- Reset mid-transaction: all state is cleared, including FIFO, pending, and any held AW/W. The response is not issued.
- irq_ready may be held high constantly; the FIFO drains at 1 vector per cycle.

## Configuration
- MSIX_RX_COALESCE_CNT_EN defined: 32-bit coalesce counter compiled in. It increments per coalesced doorbell, saturates at 32'hFFFF_FFFF, and is cleared only by reset. Status rdata[63:32] returns the counter.
- Not defined: no counter logic; status rdata[63:32] reads 0. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 4 clocks -> all outputs 0; 1 clock after release, awready=wready=arready=1, irq_valid=0.
- Single doorbell: write DOORBELL_OFFSET with wdata=6, AW and W in the same cycle -> bvalid at +1 with bresp=00; irq_valid=1, irq_vector=6; status pending=0x40. irq_ready=1 -> pending=0, irq_valid=0.
- Ordering and coalesce: irq_ready=0, doorbells 3,5,3 -> third returns OKAY; pending=0x28; counter=1 (0 without the macro). Drain with irq_ready=1 -> vectors 3 then 5 on consecutive cycles.
- Error and ignore: doorbell wdata=8 -> SLVERR, pending unchanged. Doorbell with wstrb=8'hFE -> OKAY, no push. W presented 3 cycles before AW -> single response, correct commit.
- Same-cycle pop/push: vector 2 at FIFO head with irq_ready=1 while a doorbell for 2 commits -> vector 2 is re-queued, pending[2]=1, second irq_vector=2 observed.
- Backpressure and reset: fill all 8 vectors with irq_ready=0 -> pending=0xFF. Assert rst_n=0 mid-response -> bvalid=0, irq_valid=0, pending=0.
